// File: rtl/altera_emif_ddr4_model_db_pkg.sv
// Shared types and constants for the LRDIMM DDR4 data-buffer control model.
// BCOM opcodes, BCW frame states, BCW register addresses and the latency width.
package altera_emif_ddr4_model_db_pkg;

    localparam int LAT_W = 5;

    localparam logic [3:0] BCW_RL = 4'd0;
    localparam logic [3:0] BCW_WL = 4'd1;

    typedef enum logic [2:0] {
        OP_NOP = 3'b000,
        OP_RD  = 3'b001,
        OP_WR  = 3'b010,
        OP_BCW = 3'b011
    } opcode_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BCW_ADDR,
        ST_BCW_DHI,
        ST_BCW_DLO
    } state_e;

    // Even parity across the whole nibble, including the parity bit itself.
    function automatic logic parity_ok(input logic [3:0] nib);
        return ~(^nib);
    endfunction

endpackage

// File: rtl/altera_emif_ddr4_model_db_sched.sv
// One direction's drive timeline: a load ORs a burst window at [lat, lat+BURST_CYCLES-1]
// cycles ahead into a shift register whose bit 0 is the drive enable.
module altera_emif_ddr4_model_db_sched
    import altera_emif_ddr4_model_db_pkg::*;
#(
    parameter int BURST_CYCLES = 4,
    parameter int DEPTH        = 35
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [LAT_W-1:0] lat,
    output logic             en,
    output logic             pending
);

    localparam int POS_W = $clog2(DEPTH + 1) + 1;

    logic [DEPTH-1:0] tl_reg;
    logic [DEPTH-1:0] mask;
    logic [POS_W-1:0] lo;
    logic [POS_W-1:0] hi;

    assign lo = POS_W'(lat);
    assign hi = POS_W'(lat) + POS_W'(BURST_CYCLES);

    // Bit gi reaches position 0 after gi further shifts, i.e. gi+1 cycles after the load edge.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_mask
            localparam logic [POS_W-1:0] POS = POS_W'(gi + 1);
            assign mask[gi] = (POS >= lo) && (POS < hi);
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tl_reg <= '0;
        end else begin
            tl_reg <= {1'b0, tl_reg[DEPTH-1:1]} | (load ? mask : '0);
        end
    end

    assign en      = tl_reg[0];
    assign pending = |tl_reg;

endmodule

// File: rtl/altera_emif_ddr4_model_db_ctrl.sv
// LRDIMM DDR4 data-buffer control: BCOM decode, BCW latency registers, read/write
// drive windows and ALERT_n. Define ALTERA_EMIF_DB_PARITY_EN to enable BCOM parity checking.
module altera_emif_ddr4_model_db_ctrl
    import altera_emif_ddr4_model_db_pkg::*;
#(
    parameter int RL_DEFAULT   = 11,
    parameter int WL_DEFAULT   = 9,
    parameter int BURST_CYCLES = 4,
    parameter int MAX_LAT      = 31,
    parameter int ALERT_CYCLES = 2
) (
    input  logic             BCK_t,
    input  logic             rst,
    input  logic             BCKE,
    input  logic [3:0]       BCOM,
    output logic             rd_en,
    output logic             wr_en,
    output logic [LAT_W-1:0] rl_q,
    output logic [LAT_W-1:0] wl_q,
    output logic             busy,
    output logic             ALERT_n
);

    localparam int DEPTH = MAX_LAT + BURST_CYCLES;
    localparam int CNT_W = $clog2(ALERT_CYCLES + 1);

    state_e           state_reg, state_next;
    logic [3:0]       addr_reg, addr_next;
    logic [3:0]       dhi_reg, dhi_next;
    logic [LAT_W-1:0] rl_reg, rl_next;
    logic [LAT_W-1:0] wl_reg, wl_next;
    logic [CNT_W-1:0] alert_cnt_reg, alert_cnt_next;
    logic [7:0]       bcw_data;
    logic             cmd_ok;
    logic             rd_load, wr_load;
    logic             cmd_err, bcw_err, conflict;
    logic             rd_raw, wr_raw;
    logic             rd_pending, wr_pending;

`ifdef ALTERA_EMIF_DB_PARITY_EN
    assign cmd_ok = parity_ok(BCOM);
`else
    assign cmd_ok = 1'b1;
`endif

    assign bcw_data = {dhi_reg, BCOM};

    always_comb begin
        state_next = state_reg;
        addr_next  = addr_reg;
        dhi_next   = dhi_reg;
        rl_next    = rl_reg;
        wl_next    = wl_reg;
        rd_load    = 1'b0;
        wr_load    = 1'b0;
        cmd_err    = 1'b0;
        bcw_err    = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (BCKE) begin
                    if (!cmd_ok) begin
                        cmd_err = 1'b1;
                    end else begin
                        case (BCOM[2:0])
                            OP_NOP:  ;
                            OP_RD:   rd_load    = 1'b1;
                            OP_WR:   wr_load    = 1'b1;
                            OP_BCW:  state_next = ST_BCW_ADDR;
                            default: cmd_err    = 1'b1;
                        endcase
                    end
                end
            end
            // Frame nibbles are raw data; a BCKE-low cycle simply stalls the frame.
            ST_BCW_ADDR: begin
                if (BCKE) begin
                    addr_next  = BCOM;
                    state_next = ST_BCW_DHI;
                end
            end
            ST_BCW_DHI: begin
                if (BCKE) begin
                    dhi_next   = BCOM;
                    state_next = ST_BCW_DLO;
                end
            end
            ST_BCW_DLO: begin
                if (BCKE) begin
                    state_next = ST_IDLE;
                    if ((addr_reg == BCW_RL) || (addr_reg == BCW_WL)) begin
                        if ((bcw_data == 8'd0) || (bcw_data > 8'(MAX_LAT))) begin
                            bcw_err = 1'b1;
                        end else if (addr_reg == BCW_RL) begin
                            rl_next = bcw_data[LAT_W-1:0];
                        end else begin
                            wl_next = bcw_data[LAT_W-1:0];
                        end
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign conflict = rd_raw & wr_raw;

    always_comb begin
        alert_cnt_next = alert_cnt_reg;
        if (cmd_err || bcw_err || conflict) begin
            alert_cnt_next = CNT_W'(ALERT_CYCLES);
        end else if (alert_cnt_reg != '0) begin
            alert_cnt_next = alert_cnt_reg - 1'b1;
        end
    end

    always_ff @(posedge BCK_t or posedge rst) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            addr_reg      <= '0;
            dhi_reg       <= '0;
            rl_reg        <= LAT_W'(RL_DEFAULT);
            wl_reg        <= LAT_W'(WL_DEFAULT);
            alert_cnt_reg <= '0;
        end else begin
            state_reg     <= state_next;
            addr_reg      <= addr_next;
            dhi_reg       <= dhi_next;
            rl_reg        <= rl_next;
            wl_reg        <= wl_next;
            alert_cnt_reg <= alert_cnt_next;
        end
    end

    altera_emif_ddr4_model_db_sched #(
        .BURST_CYCLES (BURST_CYCLES),
        .DEPTH        (DEPTH)
    ) u_rd_sched (
        .clk     (BCK_t),
        .rst     (rst),
        .load    (rd_load),
        .lat     (rl_reg),
        .en      (rd_raw),
        .pending (rd_pending)
    );

    altera_emif_ddr4_model_db_sched #(
        .BURST_CYCLES (BURST_CYCLES),
        .DEPTH        (DEPTH)
    ) u_wr_sched (
        .clk     (BCK_t),
        .rst     (rst),
        .load    (wr_load),
        .lat     (wl_reg),
        .en      (wr_raw),
        .pending (wr_pending)
    );

    // Reads take priority on the shared DQ bus.
    assign rd_en   = rd_raw;
    assign wr_en   = wr_raw & ~rd_raw;
    assign busy    = rd_pending | wr_pending;
    assign ALERT_n = (alert_cnt_reg == '0);
    assign rl_q    = rl_reg;
    assign wl_q    = wl_reg;

endmodule

// File: tb/tb_altera_emif_ddr4_model_db_ctrl.sv
// Self-checking bench for altera_emif_ddr4_model_db_ctrl: vector table, directed
// corner sequences and randomized BCOM traffic against a per-cycle expectation model.
module tb_altera_emif_ddr4_model_db_ctrl;

    localparam int N    = 8192;
    localparam int RL0  = 11;
    localparam int WL0  = 9;
    localparam int B    = 4;
    localparam int AC   = 2;
    localparam int MAXL = 31;

    logic       BCK_t = 1'b0;
    logic       rst   = 1'b1;
    logic       BCKE  = 1'b0;
    logic [3:0] BCOM  = 4'd0;
    logic       rd_en, wr_en, busy, ALERT_n;
    logic [4:0] rl_q, wl_q;

    always #5 BCK_t = ~BCK_t;

    altera_emif_ddr4_model_db_ctrl dut (
        .BCK_t   (BCK_t),
        .rst     (rst),
        .BCKE    (BCKE),
        .BCOM    (BCOM),
        .rd_en   (rd_en),
        .wr_en   (wr_en),
        .rl_q    (rl_q),
        .wl_q    (wl_q),
        .busy    (busy),
        .ALERT_n (ALERT_n)
    );

    // Expectation per absolute cycle since the last reset release.
    bit rd_want   [N];
    bit wr_want   [N];
    bit busy_want [N];
    bit alert_low [N];
    int cyc, m_rl, m_wl, frame_pos, f_addr, f_dhi;
    int total = 0;
    int bad   = 0;
    int rd_first, rd_last, rd_cnt, wr_first, wr_cnt, alert_cnt, both_cnt;

    typedef struct {
        logic [3:0] bcom;
        logic       bcke;
        int         rd_first;
        int         rd_cnt;
        int         wr_first;
        int         wr_cnt;
        int         alerts;
    } vec_t;
    vec_t vt[8];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s cycle=%0d actual=%0d required=%0d", name, cyc, act, exp);
        end
    endtask

    task automatic clear_stats();
        rd_first = -1; rd_last = -1; rd_cnt = 0;
        wr_first = -1; wr_cnt = 0; alert_cnt = 0; both_cnt = 0;
    endtask

    task automatic mark_err(input int c);
        for (int k = 1; k <= AC; k++) alert_low[c + k] = 1'b1;
    endtask

    // A command in cycle c drives cycles c+lat .. c+lat+B-1 and is pending from c+1.
    task automatic sched(input bit is_rd, input int c, input int lat);
        for (int k = 0; k < B; k++) begin
            if (is_rd) rd_want[c + lat + k] = 1'b1;
            else       wr_want[c + lat + k] = 1'b1;
        end
        for (int k = 1; k <= lat + B - 1; k++) busy_want[c + k] = 1'b1;
    endtask

    task automatic model_cmd(input logic [3:0] b, input logic ke);
        int  data;
        bit  par_bad;
        par_bad = 1'b0;
        if (frame_pos == 0) begin
            if (ke) begin
`ifdef ALTERA_EMIF_DB_PARITY_EN
                par_bad = ^b;
`endif
                if (par_bad) mark_err(cyc);
                else begin
                    case (int'(b[2:0]))
                        0: ;
                        1: sched(1'b1, cyc, m_rl);
                        2: sched(1'b0, cyc, m_wl);
                        3: frame_pos = 1;
                        default: mark_err(cyc);
                    endcase
                end
            end
        end else if (ke) begin
            if (frame_pos == 1) f_addr = int'(b);
            else if (frame_pos == 2) f_dhi = int'(b);
            else begin
                data = f_dhi * 16 + int'(b);
                if (f_addr < 2) begin
                    if (data == 0 || data > MAXL) mark_err(cyc);
                    else if (f_addr == 0) m_rl = data;
                    else m_wl = data;
                end
            end
            frame_pos = (frame_pos == 3) ? 0 : frame_pos + 1;
        end
    endtask

    task automatic step(input logic [3:0] b, input logic ke);
        BCOM = b;
        BCKE = ke;
        model_cmd(b, ke);
        @(posedge BCK_t);
        #1;
        cyc++;
        if (rd_want[cyc] && wr_want[cyc]) mark_err(cyc);
        chk("rd_en",   int'(rd_en),   int'(rd_want[cyc]));
        chk("wr_en",   int'(wr_en),   int'(wr_want[cyc] && !rd_want[cyc]));
        chk("busy",    int'(busy),    int'(busy_want[cyc]));
        chk("ALERT_n", int'(ALERT_n), int'(!alert_low[cyc]));
        chk("rl_q",    int'(rl_q),    m_rl);
        chk("wl_q",    int'(wl_q),    m_wl);
        if (rd_en) begin
            if (rd_first < 0) rd_first = cyc;
            rd_last = cyc;
            rd_cnt++;
        end
        if (wr_en) begin
            if (wr_first < 0) wr_first = cyc;
            wr_cnt++;
        end
        if (!ALERT_n) alert_cnt++;
        if (rd_en && wr_en) both_cnt++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(4'b0000, 1'b1);
    endtask

    // Asserted away from the clock edge so the clear must be asynchronous.
    task automatic do_reset();
        @(negedge BCK_t);
        rst  = 1'b1;
        BCOM = 4'd0;
        BCKE = 1'b0;
        #1;
        chk("rst_rd_en",   int'(rd_en),   0);
        chk("rst_wr_en",   int'(wr_en),   0);
        chk("rst_busy",    int'(busy),    0);
        chk("rst_ALERT_n", int'(ALERT_n), 1);
        chk("rst_rl_q",    int'(rl_q),    RL0);
        chk("rst_wl_q",    int'(wl_q),    WL0);
        @(posedge BCK_t);
        @(negedge BCK_t);
        rst = 1'b0;
        @(posedge BCK_t);
        #1;
        for (int i = 0; i < N; i++) begin
            rd_want[i] = 1'b0; wr_want[i] = 1'b0;
            busy_want[i] = 1'b0; alert_low[i] = 1'b0;
        end
        cyc = 0; m_rl = RL0; m_wl = WL0; frame_pos = 0; f_addr = 0; f_dhi = 0;
        clear_stats();
    endtask

    task automatic bcw(input logic [3:0] addr, input logic [7:0] data);
        step(4'b0011, 1'b1);
        step(addr, 1'b1);
        step(data[7:4], 1'b1);
        step(data[3:0], 1'b1);
    endtask

    initial begin
        vt[0] = '{4'b1001, 1'b1, 11, 4, -1, 0, 0};
        vt[1] = '{4'b1010, 1'b1, -1, 0,  9, 4, 0};
        vt[2] = '{4'b0000, 1'b1, -1, 0, -1, 0, 0};
        vt[3] = '{4'b1001, 1'b0, -1, 0, -1, 0, 0};
        vt[4] = '{4'b1100, 1'b1, -1, 0, -1, 0, 2};
        vt[5] = '{4'b0111, 1'b1, -1, 0, -1, 0, 2};
        vt[6] = '{4'b1110, 1'b1, -1, 0, -1, 0, 2};
`ifdef ALTERA_EMIF_DB_PARITY_EN
        vt[7] = '{4'b0001, 1'b1, -1, 0, -1, 0, 2};
`else
        vt[7] = '{4'b0001, 1'b1, 11, 4, -1, 0, 0};
`endif

        for (int v = 0; v < 8; v++) begin
            do_reset();
            step(vt[v].bcom, vt[v].bcke);
            idle(20);
            $display("vec %0d bcom=%b bcke=%0d rd_first=%0d rd_cnt=%0d wr_first=%0d wr_cnt=%0d alerts=%0d",
                     v, vt[v].bcom, vt[v].bcke, rd_first, rd_cnt, wr_first, wr_cnt, alert_cnt);
            chk("vec_rd_first", rd_first, vt[v].rd_first);
            chk("vec_rd_cnt",   rd_cnt,   vt[v].rd_cnt);
            chk("vec_wr_first", wr_first, vt[v].wr_first);
            chk("vec_wr_cnt",   wr_cnt,   vt[v].wr_cnt);
            chk("vec_alerts",   alert_cnt, vt[v].alerts);
        end

        // BCW sets WL=7, WR on the following cycle uses it.
        do_reset();
        bcw(4'd1, 8'd7);
        step(4'b1010, 1'b1);
        idle(16);
        $display("bcw_wl: wl_q=%0d wr_first=%0d wr_cnt=%0d alerts=%0d", wl_q, wr_first, wr_cnt, alert_cnt);
        chk("t2_wl_q",     int'(wl_q), 7);
        chk("t2_wr_first", wr_first, 11);
        chk("t2_wr_cnt",   wr_cnt, 4);
        chk("t2_alerts",   alert_cnt, 0);

        // Back-to-back reads merge into one continuous window.
        do_reset();
        step(4'b1001, 1'b1);
        idle(3);
        step(4'b1001, 1'b1);
        idle(20);
        $display("rd_merge: first=%0d last=%0d cnt=%0d alerts=%0d", rd_first, rd_last, rd_cnt, alert_cnt);
        chk("t3_rd_first", rd_first, 11);
        chk("t3_rd_last",  rd_last, 18);
        chk("t3_rd_cnt",   rd_cnt, 8);
        chk("t3_alerts",   alert_cnt, 0);

        // WR at 0 (cycles 9-12) and RD at 1 (cycles 12-15) collide on cycle 12.
        do_reset();
        step(4'b1010, 1'b1);
        step(4'b1001, 1'b1);
        idle(20);
        $display("conflict: rd_cnt=%0d wr_cnt=%0d both=%0d alerts=%0d", rd_cnt, wr_cnt, both_cnt, alert_cnt);
        chk("t4_rd_cnt", rd_cnt, 4);
        chk("t4_wr_cnt", wr_cnt, 3);
        chk("t4_both",   both_cnt, 0);
        chk("t4_alerts", alert_cnt, 2);

        // Rejected BCW values: RL=0 and WL=32.
        do_reset();
        bcw(4'd0, 8'd0);
        idle(4);
        chk("t6_rl_zero_kept",   int'(rl_q), RL0);
        chk("t6_rl_zero_alerts", alert_cnt, 2);
        clear_stats();
        bcw(4'd1, 8'd32);
        idle(4);
        $display("bcw_reject: rl_q=%0d wl_q=%0d alerts=%0d", rl_q, wl_q, alert_cnt);
        chk("t6_wl_big_kept",   int'(wl_q), WL0);
        chk("t6_wl_big_alerts", alert_cnt, 2);

        // Unknown BCW address is silently ignored; BCKE low stalls the frame.
        clear_stats();
        bcw(4'd5, 8'd0);
        step(4'b0011, 1'b1);
        step(4'b0001, 1'b1);
        step(4'b1111, 1'b0);
        step(4'b0000, 1'b1);
        step(4'b1010, 1'b0);
        step(4'b0101, 1'b1);
        idle(2);
        $display("bcw_stall: wl_q=%0d alerts=%0d", wl_q, alert_cnt);
        chk("t7_wl_stall", int'(wl_q), 5);
        chk("t7_alerts",   alert_cnt, 0);

        // Reset in the middle of a read burst with RL reprogrammed to 5.
        do_reset();
        bcw(4'd0, 8'd5);
        step(4'b1001, 1'b1);
        idle(5);
        chk("t8_rd_active", int'(rd_en), 1);
        do_reset();

        // Randomized traffic.
        begin
            int q[$];
            do_reset();
            for (int i = 0; i < 3000; i++) begin
                logic [3:0] nib;
                logic       ke;
                int         r, d;
                ke = ($urandom_range(0, 9) != 0);
                if (q.size() > 0) begin
                    if (ke) nib = 4'(q.pop_front());
                    else    nib = 4'($urandom_range(0, 15));
                end else begin
                    r = $urandom_range(0, 99);
                    if (r < 55)      nib = 4'b0000;
                    else if (r < 70) nib = 4'b1001;
                    else if (r < 85) nib = 4'b1010;
                    else if (r < 92) begin
                        nib = 4'b0011;
                        if (ke) begin
                            if ($urandom_range(0, 9) == 0)
                                d = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(32, 255);
                            else
                                d = $urandom_range(1, MAXL);
                            q.push_back($urandom_range(0, 3));
                            q.push_back(d / 16);
                            q.push_back(d % 16);
                        end
                    end else nib = 4'($urandom_range(0, 15));
                end
                step(nib, ke);
            end
            idle(40);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
